// File: rtl/ip_mem_sequencer.sv
// rtl/ip_mem_sequencer.sv - job sequencer moving words RAM port 2 -> custom IP -> RAM port 2
//
// Purpose:
//    Accepts a single command word from the core and runs a job of cnt+1
//    words: for each word it reads RAM port 2, hands the word to the
//    custom IP, waits IP_LAT cycles, then writes the IP result back to the
//    destination region through RAM port 2. The core only polls BUSY/DONE.
//
// Parameters:
//    IP_LAT  cycles from IP_DIN valid to IP_DOUT valid (1..15)
//    AW      data RAM word-address width
//
// Optional feature macro:
//    IPSEQ_BUSY_ERR_EN  when defined, ERR flags start edges seen while busy
//                       and address-range wrap past 2^AW-1; when undefined
//                       ERR is tied low and no detection logic exists.
//
// Ports:
//    CLK       in   system clock, rising edge
//    RSTN      in   asynchronous active-low reset
//    CONSIG    in   [31] start, [30:21] src, [20:11] dst, [10:3] cnt-1, [2:0] opcode
//    BUSY      out  job in progress (every state except IDLE)
//    DONE      out  one-cycle pulse at job completion
//    ERR       out  sticky error flag
//    CSN2      out  RAM port-2 chip select, active low
//    WEN2      out  RAM port-2 write enable, active low
//    A2        out  RAM port-2 word address
//    DI2       out  RAM port-2 write data
//    DO2       in   RAM port-2 read data, valid the cycle after the read
//    IP_DIN    out  operand to custom IP
//    IP_VALID  out  one-cycle strobe marking a new IP_DIN
//    IP_CON    out  {29'b0, opcode}, held for the whole job
//    IP_DOUT   in   IP result
`timescale 1ns/1ps

module ip_mem_sequencer #(
   parameter int IP_LAT = 2,
   parameter int AW     = 10
) (
   input  logic          CLK,
   input  logic          RSTN,
   input  logic [31:0]   CONSIG,
   output logic          BUSY,
   output logic          DONE,
   output logic          ERR,
   output logic          CSN2,
   output logic          WEN2,
   output logic [AW-1:0] A2,
   output logic [31:0]   DI2,
   input  logic [31:0]   DO2,
   output logic [31:0]   IP_DIN,
   output logic          IP_VALID,
   output logic [31:0]   IP_CON,
   input  logic [31:0]   IP_DOUT
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_WAIT = 3'd2,
      S_EXEC = 3'd3,
      S_WR   = 3'd4,
      S_FIN  = 3'd5
   } state_t;

   state_t        state;
   state_t        state_nxt;

   // The whole command word is registered alongside the start bit so the
   // fields latched on an accepted start are those sampled with the edge.
   logic          start_q;
   logic          start_qq;
   logic [30:0]   cmd_q;

   logic          start_edge;
   logic          start_acc;

   logic [AW-1:0] src;
   logic [AW-1:0] dst;
   logic [7:0]    cnt;
   logic [7:0]    idx;
   logic [2:0]    op;
   logic [3:0]    lat_cnt;
   logic [31:0]   result;
   logic [31:0]   ip_din_q;
   logic          ip_valid_q;

   assign start_edge = start_q & ~start_qq;
   assign start_acc  = start_edge && (state == S_IDLE);

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (start_acc) state_nxt = S_RD;
         S_RD:   state_nxt = S_WAIT;
         S_WAIT: state_nxt = S_EXEC;
         S_EXEC: if (lat_cnt == 4'd0) state_nxt = S_WR;
         S_WR:   state_nxt = (idx == cnt) ? S_FIN : S_RD;
         S_FIN:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Output logic (decoded from the registered state)
   // ------------------------------------------------------------------
   always_comb begin
      CSN2 = 1'b1;
      WEN2 = 1'b1;
      A2   = '0;
      DI2  = '0;
      case (state)
         S_RD: begin
            CSN2 = 1'b0;
            A2   = src + AW'(idx);   // wraps modulo 2^AW by width
         end
         S_WR: begin
            CSN2 = 1'b0;
            WEN2 = 1'b0;
            A2   = dst + AW'(idx);
            DI2  = result;
         end
         default: ;
      endcase
   end

   assign BUSY     = (state != S_IDLE);
   assign DONE     = (state == S_FIN);
   assign IP_CON   = BUSY ? {29'b0, op} : 32'd0;
   assign IP_DIN   = ip_din_q;
   assign IP_VALID = ip_valid_q;

   // ------------------------------------------------------------------
   // Datapath: command capture, IP handshake, latency counter, index
   // ------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         start_q    <= 1'b0;
         start_qq   <= 1'b0;
         cmd_q      <= '0;
         src        <= '0;
         dst        <= '0;
         cnt        <= '0;
         idx        <= '0;
         op         <= '0;
         lat_cnt    <= '0;
         result     <= '0;
         ip_din_q   <= '0;
         ip_valid_q <= 1'b0;
      end else begin
         start_q    <= CONSIG[31];
         start_qq   <= start_q;
         cmd_q      <= CONSIG[30:0];
         ip_valid_q <= (state == S_WAIT);

         if (start_acc) begin
            src <= AW'(cmd_q[30:21]);
            dst <= AW'(cmd_q[20:11]);
            cnt <= cmd_q[10:3];
            op  <= cmd_q[2:0];
            idx <= '0;
         end

         case (state)
            S_WAIT: begin
               // DO2 answers the read issued in RD; IP_DIN stays stable
               // for the whole EXEC window so the IP can sample any time.
               ip_din_q <= DO2;
               lat_cnt  <= 4'(IP_LAT - 1);
            end
            S_EXEC: begin
               if (lat_cnt == 4'd0) begin
                  result <= IP_DOUT;
               end else begin
                  lat_cnt <= lat_cnt - 4'd1;
               end
            end
            S_WR: begin
               idx <= idx + 8'd1;
            end
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Error flag
   // ------------------------------------------------------------------
`ifdef IPSEQ_BUSY_ERR_EN
   logic          err_q;
   logic [AW:0]   src_end;
   logic [AW:0]   dst_end;
   logic          range_wrap;

   // One extra bit catches the last word of the range crossing 2^AW-1.
   assign src_end    = {1'b0, AW'(cmd_q[30:21])} + (AW+1)'(cmd_q[10:3]);
   assign dst_end    = {1'b0, AW'(cmd_q[20:11])} + (AW+1)'(cmd_q[10:3]);
   assign range_wrap = src_end[AW] | dst_end[AW];

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         err_q <= 1'b0;
      end else if (start_acc) begin
         err_q <= range_wrap;
      end else if (start_edge && (state != S_IDLE)) begin
         err_q <= 1'b1;
      end
   end

   assign ERR = err_q;
`else
   assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_ip_mem_sequencer.sv
// tb/tb_ip_mem_sequencer.sv - scoreboard bench for ip_mem_sequencer
`timescale 1ns/1ps

module tb_ip_mem_sequencer;

   localparam int LAT = 2;
   localparam int AW  = 10;
   localparam int WORD_CYC = 3 + LAT;
`ifdef IPSEQ_BUSY_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic          CLK = 1'b0;
   logic          RSTN = 1'b0;
   logic [31:0]   CONSIG = '0;
   logic          BUSY, DONE, ERR, CSN2, WEN2, IP_VALID;
   logic [AW-1:0] A2;
   logic [31:0]   DI2, IP_DIN, IP_CON, IP_DOUT;
   logic [31:0]   DO2;

   ip_mem_sequencer #(.IP_LAT(LAT), .AW(AW)) dut (
      .CLK(CLK), .RSTN(RSTN), .CONSIG(CONSIG),
      .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
      .CSN2(CSN2), .WEN2(WEN2), .A2(A2), .DI2(DI2), .DO2(DO2),
      .IP_DIN(IP_DIN), .IP_VALID(IP_VALID), .IP_CON(IP_CON), .IP_DOUT(IP_DOUT)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   // RAM behavioural model: synchronous, read data one cycle later
   logic [31:0] mem [0:1023];
   logic [31:0] mdl [0:1023];
   always @(posedge CLK) begin
      if (!CSN2) begin
         if (!WEN2) mem[A2] <= DI2;
         else       DO2 <= mem[A2];
      end
   end

   // Mock IP: result is only correct exactly LAT-1 cycles after the strobe
   function automatic logic [31:0] ip_f(input logic [31:0] x, input logic [2:0] op);
      case (op)
         3'd0:    return x;
         3'd5:    return x + 32'd1;
         default: return x ^ {8{1'b0, op}};
      endcase
   endfunction

   int ip_age = 100;
   always @(posedge CLK) ip_age <= IP_VALID ? 1 : ((ip_age < 100) ? ip_age + 1 : ip_age);
   always @* begin
      if ((IP_VALID ? 0 : ip_age) == LAT - 1) IP_DOUT = ip_f(IP_DIN, IP_CON[2:0]);
      else                                     IP_DOUT = ~ip_f(IP_DIN, IP_CON[2:0]);
   end

   // Scoreboard
   typedef struct {
      bit          we;
      logic [9:0]  addr;
      logic [31:0] data;
   } acc_t;
   acc_t exp_q[$];
   int   done_q[$];
   int   cyc = 0;
   logic [2:0] cur_op = '0;
   bit   prev_done = 0;
   acc_t mon_e;

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (!RSTN) begin
         prev_done = 0;
      end else begin
         if (prev_done) check("busy_after_done", BUSY, 0);
         prev_done = DONE;
         if (!CSN2) begin
            check("access_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               mon_e = exp_q.pop_front();
               check("acc_we", !WEN2, mon_e.we);
               check("acc_addr", A2, mon_e.addr);
               if (mon_e.we) check("acc_data", DI2, mon_e.data);
            end
         end
         if (DONE) begin
            check("done_expected", done_q.size() > 0, 1);
            if (done_q.size() > 0) check("done_cycle", cyc, done_q.pop_front());
         end
         check("ip_con", IP_CON, BUSY ? {29'b0, cur_op} : 32'd0);
      end
   end

   // Builds expected traffic from the job description: read word w, then
   // write f(word) to dst+w, addresses modulo 1024. n_full words complete;
   // when n_full <= cnt the read of word n_full is also expected.
   task automatic issue(input logic [9:0] src, input logic [9:0] dst, input logic [7:0] cnt,
                        input logic [2:0] op, input int n_full, input bit exp_done);
      acc_t a;
      logic [31:0] v;
      for (int w = 0; w < n_full; w++) begin
         a.we = 0; a.addr = 10'((src + w) % 1024); a.data = 0;
         v = mdl[a.addr];
         exp_q.push_back(a);
         a.we = 1; a.addr = 10'((dst + w) % 1024); a.data = ip_f(v, op);
         mdl[a.addr] = a.data;
         exp_q.push_back(a);
      end
      if (n_full <= int'(cnt)) begin
         a.we = 0; a.addr = 10'((src + n_full) % 1024); a.data = 0;
         exp_q.push_back(a);
      end
      if (exp_done) done_q.push_back(cyc + 1 + (int'(cnt) + 1) * WORD_CYC + 1);
      cur_op = op;
      CONSIG = {1'b1, src, dst, cnt, op};
   endtask

   task automatic wait_busy(input bit lvl, input int budget, input string name);
      for (int k = 0; k < budget; k++) begin
         if (BUSY === lvl) break;
         @(negedge CLK);
      end
      check(name, BUSY, lvl);
   endtask

   function automatic bit wraps(input int src, input int dst, input int cnt);
      return ERR_EN && ((src + cnt > 1023) || (dst + cnt > 1023));
   endfunction

   task automatic run_job(input logic [9:0] src, input logic [9:0] dst, input logic [7:0] cnt,
                          input logic [2:0] op);
      @(negedge CLK);
      issue(src, dst, cnt, op, int'(cnt) + 1, 1);
      @(negedge CLK);
      CONSIG[31] = 1'b0;
      wait_busy(1, 10, "busy_rise");
      wait_busy(0, (int'(cnt) + 1) * WORD_CYC + 10, "busy_fall");
      check("err", ERR, wraps(src, dst, cnt));
   endtask

   initial begin
      int nv;
      int mism;
      logic [9:0] rs, rd;
      logic [7:0] rc;

      for (int k = 0; k < 1024; k++) begin
         mem[k] = $urandom;
         mdl[k] = mem[k];
      end

      // Reset state
      repeat (3) @(negedge CLK);
      check("rst_busy", BUSY, 0);
      check("rst_done", DONE, 0);
      check("rst_err", ERR, 0);
      check("rst_csn2", CSN2, 1);
      check("rst_wen2", WEN2, 1);
      check("rst_a2", A2, 0);
      check("rst_di2", DI2, 0);
      check("rst_ip_din", IP_DIN, 0);
      check("rst_ip_valid", IP_VALID, 0);
      check("rst_ip_con", IP_CON, 0);
      RSTN = 1'b1;

      // Basic job
      for (int k = 0; k < 4; k++) begin
         mem[16 + k] = k + 1;
         mdl[16 + k] = k + 1;
      end
      run_job(10'h010, 10'h020, 8'd3, 3'd5);
      for (int k = 0; k < 4; k++) check("basic_dst", mem[32 + k], k + 2);

      // Single word at the top of the address space
      mem[1023] = 32'hDEADBEEF;
      mdl[1023] = 32'hDEADBEEF;
      run_job(10'h3FF, 10'h000, 8'd0, 3'd0);
      check("single_dst", mem[0], 32'hDEADBEEF);

      // Source range wraps 0x3FF -> 0x000
      run_job(10'h3FE, 10'h100, 8'd2, 3'($urandom_range(0, 7)));

      // Start edge while busy, different fields
      @(negedge CLK);
      issue(10'h040, 10'h080, 8'd5, 3'd3, 6, 1);
      @(negedge CLK);
      CONSIG[31] = 1'b0;
      repeat (8) @(negedge CLK);
      CONSIG = {1'b0, 10'h1A0, 10'h1C0, 8'd1, 3'd6};
      @(negedge CLK);
      CONSIG[31] = 1'b1;
      @(negedge CLK);
      CONSIG[31] = 1'b0;
      wait_busy(0, 6 * WORD_CYC + 10, "busy_fall_dup");
      check("err_dup_start", ERR, ERR_EN);
      repeat (12) @(negedge CLK);
      check("no_second_job", BUSY, 0);

      // Start held high through DONE
      @(negedge CLK);
      issue(10'h200, 10'h300, 8'd2, 3'd1, 3, 1);
      wait_busy(1, 10, "busy_rise_held");
      wait_busy(0, 3 * WORD_CYC + 10, "busy_fall_held");
      repeat (20) @(negedge CLK);
      check("held_no_rerun", BUSY, 0);
      check("held_err", ERR, 0);
      CONSIG[31] = 1'b0;
      run_job(10'h210, 10'h310, 8'd1, 3'd2);

      // Randomized jobs
      for (int j = 0; j < 6; j++) begin
         rs = 10'($urandom);
         rd = 10'($urandom);
         rc = 8'($urandom_range(0, 15));
         run_job(rs, rd, rc, 3'($urandom));
      end

      // Reset during EXEC of word 2 of 4
      @(negedge CLK);
      issue(10'h050, 10'h060, 8'd3, 3'd2, 2, 0);
      @(negedge CLK);
      CONSIG[31] = 1'b0;
      nv = 0;
      for (int k = 0; k < 40 && nv < 3; k++) begin
         @(negedge CLK);
         if (IP_VALID) nv++;
      end
      check("third_ip_valid", nv, 3);
      #2 RSTN = 1'b0;
      #1;
      check("midrst_csn2", CSN2, 1);
      check("midrst_busy", BUSY, 0);
      check("midrst_ip_con", IP_CON, 0);
      check("midrst_ip_din", IP_DIN, 0);
      @(negedge CLK);
      check("midrst_queue_drained", exp_q.size(), 0);
      #2 RSTN = 1'b1;
      cur_op = 3'd0;
      run_job(10'h0A0, 10'h0C0, 8'd3, 3'd4);

      // Whole memory against the model
      repeat (3) @(negedge CLK);
      mism = 0;
      for (int k = 0; k < 1024; k++) if (mem[k] !== mdl[k]) mism++;
      check("mem_mismatches", mism, 0);
      check("exp_queue_empty", exp_q.size(), 0);
      check("done_queue_empty", done_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=%0t required=finish", $time);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ip_mem_sequencer.md
Name: ip_mem_sequencer

Overview:
- Job sequencer between the core's CONSIG command output and the data RAM's second port / custom IP datapath.
- On a start command it reads N words from data RAM port 2, presents each to the custom IP, waits a fixed IP latency, then writes each result back to a destination region through port 2.
- Frees the core from per-word IP traffic; the core only issues a command word and polls BUSY/DONE.

Parameters:
- IP_LAT, 2, cycles from IP_DIN valid to IP_DOUT valid (1..15).
- AW, 10, data RAM word-address width.

Ports:
- CLK  input  1  system clock, rising edge.
- RSTN  input  1  asynchronous active-low reset.
- CONSIG  input  32  command word from core: [31] start, [30:21] src word addr, [20:11] dst word addr, [10:3] word count minus 1, [2:0] IP opcode.
- BUSY  output  1  job in progress.
- DONE  output  1  one-cycle pulse at job completion.
- ERR  output  1  sticky error flag (see Optional Feature).
- CSN2  output  1  RAM port-2 chip select, active low.
- WEN2  output  1  RAM port-2 write enable, active low.
- A2  output  AW  RAM port-2 word address.
- DI2  output  32  RAM port-2 write data.
- DO2  input  32  RAM port-2 read data, valid the cycle after the read request.
- IP_DIN  output  32  operand to custom IP.
- IP_VALID  output  1  one-cycle strobe: IP_DIN is new.
- IP_CON  output  32  IP control: {29'b0, opcode}, held for the whole job.
- IP_DOUT  input  32  IP result.

Behaviour:
- Reset values: BUSY=0, DONE=0, ERR=0, CSN2=1, WEN2=1, A2=0, DI2=0, IP_DIN=0, IP_VALID=0, IP_CON=0, state=IDLE.
- Start detect: CONSIG[31] is registered every cycle. A start is a rising edge (CONSIG[31]=1 and previous=0) sampled while in IDLE.
- On start: latch src, dst, cnt=CONSIG[10:3], opcode, and i=0. Drive IP_CON; go to RD.
- States and transitions: IDLE -> RD -> WAIT -> EXEC (IP_LAT cycles) -> WR -> (i==cnt ? FIN : RD); FIN -> IDLE.
- RD: CSN2=0, WEN2=1, A2=src+i.
- WAIT: register DO2 into IP_DIN; IP_VALID=1 for this one cycle only.
- EXEC: down-counter runs IP_LAT cycles. On the last EXEC cycle, capture IP_DOUT into a result register.
- WR: CSN2=0, WEN2=0, A2=dst+i, DI2=result. Increment i.
- FIN: DONE=1 for exactly one cycle; IP_CON returns to 0 on exit.
- Outside RD/WR: CSN2=1, WEN2=1.
- BUSY=1 in every state except IDLE, including FIN.
- Cost per word is 3+IP_LAT cycles; a job takes (cnt+1)*(3+IP_LAT)+1 cycles from the start-detect edge to DONE.
- Address arithmetic is modulo 2^AW: src+i and dst+i wrap 1023 -> 0 silently.
- Count field 0 means 1 word; 255 means 256 words.
- Start edges while not IDLE are ignored; the running job is unaffected.
- A start edge in the same cycle as FIN is ignored. The core must drop and re-raise CONSIG[31].
- Overlapping src/dst regions are not checked; the sequence is strictly read i, then write i.
- RSTN asserted mid-job returns all outputs to reset values immediately. No further RAM access occurs and the job is discarded.

Optional Feature:
- Macro IPSEQ_BUSY_ERR_EN.
- Defined: ERR sets when a start edge arrives while BUSY=1, or when src+cnt or dst+cnt wraps past 2^AW-1. ERR is sticky and clears only on reset or the next accepted start that has no wrap. The job still runs.
- Undefined: ERR is tied to 0 and no detection logic is built.

Test Plan:
- Basic job: IP_LAT=2; RAM[0x010..0x013]=1,2,3,4; mock IP returns IP_DIN+1; CONSIG={1,0x010,0x020,8'd3,3'd5} -> RAM[0x020..0x023]=2,3,4,5; IP_CON=5 during the job; DONE pulses exactly 21 cycles after the start-detect edge; BUSY falls the next cycle.
- Single word: count=0, src=0x3FF, dst=0x000, RAM[0x3FF]=0xDEADBEEF, identity IP -> RAM[0x000]=0xDEADBEEF; exactly one RD and one WR; DONE at cycle 6.
- Wrap: src=0x3FE, count=2, dst=0x100 -> reads addresses 0x3FE, 0x3FF, 0x000 in order. With IPSEQ_BUSY_ERR_EN defined, ERR=1.
- Start while busy: re-pulse CONSIG[31] mid-job with different fields -> original job completes unchanged, no second job runs; ERR=1 only if the macro is defined, otherwise ERR stays 0.
- Held start: keep CONSIG[31]=1 through DONE -> no second job runs until [31] goes 0 then 1.
- Reset mid-job: assert RSTN low during EXEC of word 2 of 4 -> CSN2=1 and BUSY=0 immediately; destination words 2..3 remain unwritten; a new start after release runs normally.
